// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared types and default sizing for the RX packet/status FIFO.
// Phase enum used by the pairing FSM plus default width/depth constants.
package rx_pkt_pkg;

  typedef enum logic {
    PH_STS = 1'b0,
    PH_DAT = 1'b1
  } phase_e;

  localparam int DEF_DATA_W       = 64;
  localparam int DEF_STS_W        = 32;
  localparam int DEF_DATA_AW      = 9;
  localparam int DEF_STS_AW       = 9;
  localparam int DEF_AFULL_MARGIN = 16;

endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through FIFO.
// Read data is the head entry, combinationally; a push at full is only taken with a pop.
module sync_fwft_fifo
  import rx_pkt_pkg::*;
#(
  parameter int W            = DEF_DATA_W,
  parameter int AW           = DEF_DATA_AW,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wdata,
  input  logic          wren,
  output logic [W-1:0]  rdata,
  input  logic          rden,
  output logic          afull,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MARGIN_V = (AW+1)'(AFULL_MARGIN);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rd_ok;
  logic          wr_ok;
  logic [AW:0]   free;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_V);
  assign count = cnt_q;
  assign free  = DEPTH_V - cnt_q;
  assign afull = (free <= MARGIN_V);
  assign rdata = mem[rp_q];

  assign rd_ok = rden && !empty;
  assign wr_ok = wren && (!full || rd_ok);

  // next pointers and occupancy
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_ok) wp_d = wp_q + AW'(1);
    if (rd_ok) rp_d = rp_q + AW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp_q] <= wdata;
  end

endmodule

// File: rtl/rx_pkt_sts_fifo.sv
// rx_pkt_sts_fifo: paired status/data AXIS FIFOs gated by an alternating phase FSM.
// Optional RX_PKT_CNT_EN adds saturating pkt_cnt/drop_cnt outputs.
module rx_pkt_sts_fifo
  import rx_pkt_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STS_W        = DEF_STS_W,
  parameter int DATA_AW      = DEF_DATA_AW,
  parameter int STS_AW       = DEF_STS_AW,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN,
  parameter int STS_FIRST    = 1
) (
  input  logic                        s2mm_clk,
  input  logic                        sys_rst,
  input  logic [DATA_W+DATA_W/8:0]    dat_wdata,
  input  logic                        dat_wren,
  output logic                        dat_afull,
  input  logic [STS_W+STS_W/8:0]      sts_wdata,
  input  logic                        sts_wren,
  output logic                        sts_afull,
  output logic [DATA_W-1:0]           rxd_tdata,
  output logic [DATA_W/8-1:0]         rxd_tkeep,
  output logic                        rxd_tlast,
  output logic                        rxd_tvalid,
  input  logic                        rxd_tready,
  output logic [STS_W-1:0]            rxs_tdata,
  output logic [STS_W/8-1:0]          rxs_tkeep,
  output logic                        rxs_tlast,
  output logic                        rxs_tvalid,
  input  logic                        rxs_tready,
  output logic                        phase,
  output logic                        ovf
`ifdef RX_PKT_CNT_EN
  ,
  output logic [31:0]                 pkt_cnt,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int DWW = DATA_W + DATA_W/8 + 1;
  localparam int SWW = STS_W + STS_W/8 + 1;
  localparam phase_e PH_RST = (STS_FIRST != 0) ? PH_STS : PH_DAT;

  logic [DWW-1:0]  dat_rdata;
  logic [SWW-1:0]  sts_rdata;
  logic            dat_full, dat_empty;
  logic            sts_full, sts_empty;
  logic [DATA_AW:0] dat_count;
  logic [STS_AW:0]  sts_count;
  logic            dat_rden, sts_rden;
  logic            dat_drop, sts_drop;
  phase_e          ph_q, ph_d;
  logic            ovf_q, ovf_d;
  logic            unused_cnt;

  sync_fwft_fifo #(
    .W(DWW), .AW(DATA_AW), .AFULL_MARGIN(AFULL_MARGIN)
  ) u_dat_fifo (
    .clk(s2mm_clk), .rst(sys_rst),
    .wdata(dat_wdata), .wren(dat_wren),
    .rdata(dat_rdata), .rden(dat_rden),
    .afull(dat_afull), .full(dat_full),
    .empty(dat_empty), .count(dat_count)
  );

  sync_fwft_fifo #(
    .W(SWW), .AW(STS_AW), .AFULL_MARGIN(AFULL_MARGIN)
  ) u_sts_fifo (
    .clk(s2mm_clk), .rst(sys_rst),
    .wdata(sts_wdata), .wren(sts_wren),
    .rdata(sts_rdata), .rden(sts_rden),
    .afull(sts_afull), .full(sts_full),
    .empty(sts_empty), .count(sts_count)
  );

  assign unused_cnt = ^{dat_count, sts_count};

  assign rxd_tdata  = dat_rdata[DATA_W-1:0];
  assign rxd_tkeep  = dat_rdata[DATA_W +: DATA_W/8];
  assign rxd_tlast  = dat_rdata[DWW-1];
  assign rxs_tdata  = sts_rdata[STS_W-1:0];
  assign rxs_tkeep  = sts_rdata[STS_W +: STS_W/8];
  assign rxs_tlast  = sts_rdata[SWW-1];

  assign rxd_tvalid = !dat_empty && (ph_q == PH_DAT);
  assign rxs_tvalid = !sts_empty && (ph_q == PH_STS);
  assign dat_rden   = rxd_tvalid && rxd_tready;
  assign sts_rden   = rxs_tvalid && rxs_tready;

  // a push at full is lost unless the same cycle pops
  assign dat_drop   = dat_wren && dat_full && !dat_rden;
  assign sts_drop   = sts_wren && sts_full && !sts_rden;

  assign phase = (ph_q == PH_DAT);
  assign ovf   = ovf_q;

  // phase flips only on an accepted last beat
  always_comb begin
    ph_d  = ph_q;
    ovf_d = ovf_q | dat_drop | sts_drop;
    unique case (ph_q)
      PH_STS:  if (sts_rden && rxs_tlast) ph_d = PH_DAT;
      PH_DAT:  if (dat_rden && rxd_tlast) ph_d = PH_STS;
      default: ph_d = PH_RST;
    endcase
  end

  // phase FSM and sticky overflow
  always_ff @(posedge s2mm_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ph_q  <= PH_RST;
      ovf_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef RX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q}
                  + 17'(dat_drop) + 17'(sts_drop);

  // saturating packet and drop counters
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (dat_rden && rxd_tlast && (pkt_cnt_q != 32'hFFFF_FFFF))
      pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge s2mm_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_pkt_sts_fifo.sv
// tb_rx_pkt_sts_fifo: directed self-checking bench for rx_pkt_sts_fifo.
// Default parameters (STS_FIRST=1, 512-deep FIFOs, margin 16).
module tb_rx_pkt_sts_fifo;

  localparam int DW = 64;
  localparam int SW = 32;

  logic              s2mm_clk = 1'b0;
  logic              sys_rst  = 1'b1;
  logic [DW+DW/8:0]  dat_wdata;
  logic              dat_wren;
  logic              dat_afull;
  logic [SW+SW/8:0]  sts_wdata;
  logic              sts_wren;
  logic              sts_afull;
  logic [DW-1:0]     rxd_tdata;
  logic [DW/8-1:0]   rxd_tkeep;
  logic              rxd_tlast;
  logic              rxd_tvalid;
  logic              rxd_tready;
  logic [SW-1:0]     rxs_tdata;
  logic [SW/8-1:0]   rxs_tkeep;
  logic              rxs_tlast;
  logic              rxs_tvalid;
  logic              rxs_tready;
  logic              phase;
  logic              ovf;
`ifdef RX_PKT_CNT_EN
  logic [31:0]       pkt_cnt;
  logic [15:0]       drop_cnt;
`endif

  always #5 s2mm_clk = ~s2mm_clk;

  rx_pkt_sts_fifo dut (
    .s2mm_clk(s2mm_clk), .sys_rst(sys_rst),
    .dat_wdata(dat_wdata), .dat_wren(dat_wren), .dat_afull(dat_afull),
    .sts_wdata(sts_wdata), .sts_wren(sts_wren), .sts_afull(sts_afull),
    .rxd_tdata(rxd_tdata), .rxd_tkeep(rxd_tkeep), .rxd_tlast(rxd_tlast),
    .rxd_tvalid(rxd_tvalid), .rxd_tready(rxd_tready),
    .rxs_tdata(rxs_tdata), .rxs_tkeep(rxs_tkeep), .rxs_tlast(rxs_tlast),
    .rxs_tvalid(rxs_tvalid), .rxs_tready(rxs_tready),
    .phase(phase), .ovf(ovf)
`ifdef RX_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge s2mm_clk);
    #1;
  endtask

  task automatic wr_dat(input logic l, input logic [7:0] k,
                        input logic [63:0] d);
    dat_wdata = {l, k, d};
    dat_wren  = 1'b1;
    step();
    dat_wren  = 1'b0;
  endtask

  task automatic wr_sts(input logic l, input logic [3:0] k,
                        input logic [31:0] d);
    sts_wdata = {l, k, d};
    sts_wren  = 1'b1;
    step();
    sts_wren  = 1'b0;
  endtask

  task automatic do_reset();
    dat_wren = 1'b0;
    sts_wren = 1'b0;
    sys_rst  = 1'b1;
    step();
    step();
    sys_rst  = 1'b0;
    step();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dat_wdata  = '0;
    dat_wren   = 1'b0;
    sts_wdata  = '0;
    sts_wren   = 1'b0;
    rxd_tready = 1'b0;
    rxs_tready = 1'b0;
    sys_rst    = 1'b1;
    step();
    step();

    chk("rst_rxd_tvalid", rxd_tvalid, 0);
    chk("rst_rxs_tvalid", rxs_tvalid, 0);
    chk("rst_dat_afull", dat_afull, 0);
    chk("rst_sts_afull", sts_afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_phase", phase, 0);
    sys_rst = 1'b0;
    step();

    // single status beat, fall-through and phase flip
    rxs_tready = 1'b1;
    rxd_tready = 1'b1;
    wr_sts(1'b1, 4'hF, 32'hA5A5_A5A5);
    chk("s1_rxs_tvalid", rxs_tvalid, 1);
    chk("s1_rxs_tdata", rxs_tdata, 32'hA5A5_A5A5);
    chk("s1_rxs_tlast", rxs_tlast, 1);
    chk("s1_phase_sts", phase, 0);
    step();
    chk("s1_phase_dat", phase, 1);
    chk("s1_rxs_drained", rxs_tvalid, 0);

    // data before status is held back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_dat(i == 3, 8'hFF, 64'(100 + i));
      chk("s2_hold", rxd_tvalid, 0);
    end
    step();
    chk("s2_hold_idle", rxd_tvalid, 0);
    wr_sts(1'b1, 4'hF, 32'h1);
    chk("s2_hold_sts", rxd_tvalid, 0);
    step();
    chk("s2_phase_dat", phase, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_beat%0d", i),
          {rxd_tvalid, rxd_tlast, rxd_tdata},
          {1'b1, i == 3, 64'(100 + i)});
      step();
    end
    chk("s2_phase_back", phase, 0);
    chk("s2_empty", rxd_tvalid, 0);

    // backpressure mid-packet
    for (int i = 0; i < 3; i++)
      wr_dat(i == 2, 8'(17 * (i + 1)), 64'(32'h200 + i));
    wr_sts(1'b1, 4'hF, 32'h2);
    step();
    chk("s3_first", {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
        {1'b1, 1'b0, 8'h11, 64'h200});
    step();
    rxd_tready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("s3_stall", {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
          {1'b1, 1'b0, 8'h22, 64'h201});
      step();
    end
    rxd_tready = 1'b1;
    chk("s3_resume", {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
        {1'b1, 1'b0, 8'h22, 64'h201});
    step();
    chk("s3_last", {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
        {1'b1, 1'b1, 8'h33, 64'h202});
    step();
    chk("s3_done", {rxd_tvalid, phase}, 2'b00);

    // fill to full, overflow, ordered drain
    do_reset();
    rxd_tready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      wr_dat(1'b0, 8'(i), 64'(i));
      if (i == 494) chk("s4_afull_495", dat_afull, 0);
      if (i == 495) chk("s4_afull_496", dat_afull, 1);
    end
    chk("s4_full_cnt", dut.u_dat_fifo.count, 512);
    chk("s4_afull_512", dat_afull, 1);
    chk("s4_ovf_pre", ovf, 0);
    wr_dat(1'b1, 8'hFF, 64'hDEAD);
    chk("s4_ovf", ovf, 1);
    chk("s4_cnt_drop", dut.u_dat_fifo.count, 512);
    wr_sts(1'b1, 4'hF, 32'h4);
    step();
    chk("s4_phase", phase, 1);
    rxd_tready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      chk($sformatf("s4_rd%0d", i),
          {rxd_tvalid, rxd_tlast, rxd_tkeep, rxd_tdata},
          {1'b1, 1'b0, 8'(i), 64'(i)});
      step();
    end
    chk("s4_drained", rxd_tvalid, 0);
    chk("s4_ovf_sticky", ovf, 1);
    chk("s4_phase_hold", phase, 1);

    // reset mid data packet
    do_reset();
    chk("s5_ovf_clr", ovf, 0);
    rxd_tready = 1'b0;
    wr_sts(1'b1, 4'hF, 32'h5);
    wr_dat(1'b0, 8'hFF, 64'h500);
    wr_dat(1'b0, 8'hFF, 64'h501);
    wr_dat(1'b1, 8'hFF, 64'h502);
    chk("s5_in_dat", {phase, rxd_tvalid}, 2'b11);
    rxd_tready = 1'b1;
    step();
    rxd_tready = 1'b0;
    chk("s5_mid", rxd_tdata, 64'h501);
    sys_rst = 1'b1;
    #1;
    chk("s5_rst_rxd", rxd_tvalid, 0);
    chk("s5_rst_phase", phase, 0);
    chk("s5_rst_dcnt", dut.u_dat_fifo.count, 0);
    chk("s5_rst_scnt", dut.u_sts_fifo.count, 0);
    step();
    sys_rst = 1'b0;
    step();
    chk("s5_post", {rxd_tvalid, rxs_tvalid, phase}, 3'b000);
    wr_sts(1'b1, 4'hF, 32'h6);
    chk("s5_new_sts", {rxs_tvalid, rxs_tdata}, {1'b1, 32'h6});

    // simultaneous push/pop at full
    do_reset();
    rxd_tready = 1'b0;
    for (int i = 0; i < 512; i++)
      wr_dat(1'b0, 8'hFF, 64'(i));
    wr_sts(1'b1, 4'hF, 32'h7);
    step();
    chk("s6_full", {phase, dut.u_dat_fifo.count}, {1'b1, 10'd512});
    rxd_tready = 1'b1;
    wr_dat(1'b0, 8'hFF, 64'hF00);
    rxd_tready = 1'b0;
    chk("s6_full_rw_cnt", dut.u_dat_fifo.count, 512);
    chk("s6_full_rw_ovf", ovf, 0);
    chk("s6_full_rw_head", rxd_tdata, 64'h1);

    // push/pop around empty
    do_reset();
    wr_sts(1'b1, 4'hF, 32'h8);
    step();
    rxd_tready = 1'b1;
    wr_dat(1'b0, 8'hFF, 64'hE0);
    chk("s7_fwft", {rxd_tvalid, rxd_tdata}, {1'b1, 64'hE0});
    chk("s7_cnt1", dut.u_dat_fifo.count, 1);
    wr_dat(1'b0, 8'hFF, 64'hE1);
    chk("s7_rw_cnt", dut.u_dat_fifo.count, 1);
    chk("s7_rw_head", rxd_tdata, 64'hE1);
    step();
    chk("s7_empty", {rxd_tvalid, dut.u_dat_fifo.count}, 11'd0);

`ifdef RX_PKT_CNT_EN
    do_reset();
    rxd_tready = 1'b1;
    rxs_tready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wr_sts(1'b1, 4'hF, 32'(p));
      step();
      wr_dat(1'b1, 8'hFF, 64'(p));
      step();
    end
    chk("s8_pkt_cnt", pkt_cnt, 3);
    chk("s8_drop_cnt", drop_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_pkt_sts_fifo.md
RX_PKT_STS_FIFO -- requirements
Module: rx_pkt_sts_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the data stream width in bits (multiple of 8).
REQ-002 The block SHALL have parameter STS_W, default 32, meaning the status stream width in bits (multiple of 8).
REQ-003 The block SHALL have parameter DATA_AW, default 9, meaning the data FIFO depth as 2**DATA_AW entries.
REQ-004 The block SHALL have parameter STS_AW, default 9, meaning the status FIFO depth as 2**STS_AW entries.
REQ-005 The block SHALL have parameter AFULL_MARGIN, default 16, meaning the number of free entries at or below which almost-full asserts.
REQ-006 The block SHALL have parameter STS_FIRST, default 1: 1 means status packet precedes its data packet; 0 means data precedes status.
REQ-007 The block SHALL have these ports, clock and reset first:
- s2mm_clk  in  1  clock; all logic on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- dat_wdata  in  DATA_W+DATA_W/8+1  {last, keep, data}.
- dat_wren  in  1  data write strobe.
- dat_afull  out  1  data FIFO almost full.
- sts_wdata  in  STS_W+STS_W/8+1  {last, keep, data}.
- sts_wren  in  1  status write strobe.
- sts_afull  out  1  status FIFO almost full.
- rxd_tdata / rxd_tkeep / rxd_tlast / rxd_tvalid  out  DATA_W / DATA_W/8 / 1 / 1  AXIS data master.
- rxd_tready  in  1  data sink ready.
- rxs_tdata / rxs_tkeep / rxs_tlast / rxs_tvalid  out  STS_W / STS_W/8 / 1 / 1  AXIS status master.
- rxs_tready  in  1  status sink ready.
- phase  out  1  0 = status phase, 1 = data phase.
- ovf  out  1  sticky overflow flag (write while full).

Function
REQ-008 Each FIFO SHALL be synchronous, first-word-fall-through; a word written in cycle N SHALL be presented on tdata/tvalid in cycle N+1 when the FIFO was empty and the phase permits.
REQ-009 The phase FSM SHALL have two states, PH_STS and PH_DAT, and SHALL leave reset in PH_STS if STS_FIRST=1, otherwise in PH_DAT.
REQ-010 rxs_tvalid SHALL equal (status FIFO not empty) AND (phase==PH_STS); rxd_tvalid SHALL equal (data FIFO not empty) AND (phase==PH_DAT).
REQ-011 A beat SHALL transfer only when tvalid AND tready; tdata, tkeep and tlast SHALL hold stable while tvalid is high and tready is low.
REQ-012 On accepting a status beat with rxs_tlast=1, the FSM SHALL move PH_STS->PH_DAT in the next cycle; on accepting a data beat with rxd_tlast=1, it SHALL move PH_DAT->PH_STS.
REQ-013 A non-last beat SHALL NOT change the phase.
REQ-014 The FIFO occupancy counters SHALL be DATA_AW+1 and STS_AW+1 bits wide; read and write pointers SHALL wrap modulo depth.
REQ-015 A simultaneous write and read on the same FIFO SHALL leave occupancy unchanged, including at full and at empty-with-fall-through.
REQ-016 A write when the FIFO is full SHALL be discarded without changing state and SHALL set ovf; ovf SHALL clear only on reset.
REQ-017 afull SHALL assert combinationally from registered occupancy when free entries <= AFULL_MARGIN.

Reset
REQ-018 On sys_rst, the block SHALL empty both FIFOs, set phase to the REQ-009 state, and drive tvalid=0, afull=0 and ovf=0; tdata contents are don't-care.
REQ-019 A reset asserted mid-packet SHALL discard all buffered beats; the first beat after reset SHALL be treated as the start of a new pair.

Configuration
REQ-020 With macro RX_PKT_CNT_EN defined, the block SHALL add two outputs, pkt_cnt[31:0] and drop_cnt[15:0]: pkt_cnt increments on each accepted rxd_tlast beat, drop_cnt increments on each discarded write, both saturate, and both reset to 0.
REQ-021 Without RX_PKT_CNT_EN, those ports and their counters SHALL be absent.

Structure
REQ-022 A shared package rx_pkt_pkg SHALL hold the phase enum (PH_STS, PH_DAT) and the default width and depth constants.
REQ-023 One sub-module, sync_fwft_fifo (parameters W and AW; outputs afull, full, empty, count), SHALL be instantiated twice.

Verification
REQ-024 Reset then write status beat {last=1, data=0xA5A5A5A5}, with tready=1 -> rxs_tvalid=1 one cycle later; phase=1 the cycle after the accept.
REQ-025 Data written before any status, STS_FIRST=1 -> rxd_tvalid stays 0 until the status tlast is accepted; then 4 data beats stream out, and phase returns to 0 after the last beat.
REQ-026 Fill the data FIFO to 512, then write once more -> ovf=1, the beat is dropped, and 512 beats read back in order; dat_afull=1 at 496 entries and above.
REQ-027 Hold rxd_tready low for 10 cycles mid-packet -> tdata, tkeep and tlast stay stable, and no beat is lost or duplicated.
REQ-028 Pulse sys_rst mid-data-packet -> both FIFOs read empty, and phase=0 with STS_FIRST=1 (phase=1 with STS_FIRST=0).
REQ-029 Simultaneous write and read at full, and at empty -> count unchanged; in the RX_PKT_CNT_EN build, pkt_cnt equals the number of packets sent.
